// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - load unit: data-memory read, byte-lane extract, sign/zero extend
//
// Purpose: accepts one load request (addr, func3), reads the 256 x 64-bit data
// memory through its synchronous read port and returns the aligned, extended
// result through a held valid/ready response.
//
// Optional feature macro: MISALIGNED_LOAD_EN
//   defined   - any byte offset is legal; word-crossing loads read two words
//   undefined - loads must be naturally aligned, otherwise resp_err=1
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid, req_ready   request handshake (req_ready high only in IDLE)
//   addr[63:0], func3[2:0] byte address (bits 10:0 used), load type
//   mem_re, mem_addr[7:0]  memory read strobe and word index
//   mem_rdata[63:0]        memory read data, valid the cycle after mem_re
//   resp_valid, resp_ready response handshake (held until accepted)
//   resp_data[63:0]        extended load result (0 on error)
//   resp_err               misaligned or illegal-func3 request

module mem_load_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] addr,
    input  logic [2:0]  func3,
    output logic        mem_re,
    output logic [7:0]  mem_addr,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_off;
    logic [2:0]  r_func3;
    logic [7:0]  r_word;
    logic        r_err;
    logic [63:0] r_data;
    logic        r_resp_err;
    logic [3:0]  w_req_size;
    logic        w_req_err;
    logic [63:0] w_single_res;

    // addr[63:11] lies outside the 2 KiB data memory and is ignored.
    logic w_unused;
    assign w_unused = &{1'b0, addr[63:11]};

    // Access size in bytes, from func3[1:0] (lb/lbu=1 ... ld=8).
    function automatic logic [3:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Shift the addressed byte lane down to bit 0, then truncate and extend.
    function automatic logic [63:0] extract(input logic [127:0] comb,
                                            input logic [2:0]   off,
                                            input logic [2:0]   f);
        logic [63:0] sh;
        sh = 64'(comb >> {off, 3'b000});
        case (f)
            3'b000:  return {{56{sh[7]}},  sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b011:  return sh;
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    assign w_req_size = size_of(func3[1:0]);

`ifdef MISALIGNED_LOAD_EN
    logic [63:0] r_low;
    logic [3:0]  w_size_rd;
    logic        w_split;
    logic [63:0] w_split_res;

    assign w_req_err   = (func3 == 3'b111);
    assign w_size_rd   = size_of(r_func3[1:0]);
    // A load whose last byte falls past lane 7 continues in the next word.
    assign w_split     = ({2'b00, r_off} + {1'b0, w_size_rd}) > 5'd8;
    assign w_split_res = extract({mem_rdata, r_low}, r_off, r_func3);
`else
    assign w_req_err = (func3 == 3'b111) ||
                       (({1'b0, addr[2:0]} & (w_req_size - 4'd1)) != 4'd0);
`endif

    assign w_single_res = extract({64'd0, mem_rdata}, r_off, r_func3);

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = r_word;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_addr  = addr[10:3];
                if (req_valid) begin
                    w_next = S_RD0;
                    mem_re = !w_req_err;
                end
            end
            S_RD0: begin
                w_next = S_RESP;
`ifdef MISALIGNED_LOAD_EN
                if (!r_err && w_split) begin
                    mem_re   = 1'b1;
                    mem_addr = r_word + 8'd1;   // wraps 255 -> 0
                    w_next   = S_RD1;
                end
`endif
            end
            S_RD1: begin
`ifdef MISALIGNED_LOAD_EN
                w_next = S_RESP;
`else
                w_next = S_IDLE;
`endif
            end
            S_RESP: begin
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            req_ready = 1'b0;
            mem_re    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_off      <= 3'd0;
            r_func3    <= 3'd0;
            r_word     <= 8'd0;
            r_err      <= 1'b0;
            r_data     <= 64'd0;
            r_resp_err <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
            r_low      <= 64'd0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_off   <= addr[2:0];
                        r_func3 <= func3;
                        r_word  <= addr[10:3];
                        r_err   <= w_req_err;
                    end
                end
                S_RD0: begin
`ifdef MISALIGNED_LOAD_EN
                    r_low <= mem_rdata;
`endif
                    if (r_err) begin
                        r_data     <= 64'd0;
                        r_resp_err <= 1'b1;
                    end else if (w_next == S_RESP) begin
                        r_data     <= w_single_res;
                        r_resp_err <= 1'b0;
                    end
                end
`ifdef MISALIGNED_LOAD_EN
                S_RD1: begin
                    r_data     <= w_split_res;
                    r_resp_err <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_data;
    assign resp_err   = r_resp_err;

endmodule
